a25_cache_flush_ctrl: RTL and testbench

//  Sequences a full invalidate of the Amber 25 cache tag RAM. It is triggered by
//  the CP15 register-1 write pulse or by an access to a disruptive area.
//  It stalls the core, waits for the cache to go idle, then writes one invalid
//  tag per cycle across every line and reports completion.
//  It sits between the coprocessor, the core stall logic and the cache tag RAM write port.

---
 rtl/a25_cache_flush_ctrl.sv | 99 +++++++++
 tb/tb_a25_cache_flush_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/a25_cache_flush_ctrl.sv
// Cache tag RAM flush sequencer: stalls the core, waits for the cache to go idle,
// then writes an invalid tag to every line and signals completion.
module a25_cache_flush_ctrl #(
   parameter int CACHE_LINES  = 256,
   parameter int CACHE_LINE_W = 8,
   parameter int TAG_W        = 21
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_flush_req,
   input  logic                    i_disruptive_hit,
   input  logic                    i_cache_idle,
   output logic                    o_stall,
   output logic                    o_busy,
   output logic                    o_tag_wenable,
   output logic [CACHE_LINE_W-1:0] o_tag_addr,
   output logic [TAG_W-1:0]        o_tag_wdata,
   output logic                    o_flush_done,
   output logic [15:0]             o_flush_count
);

   // state     | meaning
   // IDLE      | no flush requested, core runs
   // WAIT_IDLE | core stalled, waiting for fills/writebacks to drain
   // FLUSH     | writing an invalid tag to line 'line_cnt' each cycle
   // DONE      | last line written; count it, restart if another request arrived
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_IDLE = 2'd1,
      FLUSH     = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam logic [CACHE_LINE_W-1:0] LAST_LINE = CACHE_LINE_W'(CACHE_LINES - 1);

   state_t                  state, state_nxt;
   logic [CACHE_LINE_W-1:0] line_cnt, line_cnt_nxt;
   logic                    pending, pending_nxt;
   logic [15:0]             flush_count;
   logic                    req;

   assign req = i_flush_req | i_disruptive_hit;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         line_cnt    <= '0;
         pending     <= 1'b0;
         flush_count <= '0;
      end else begin
         state    <= state_nxt;
         line_cnt <= line_cnt_nxt;
         pending  <= pending_nxt;
         if (state == DONE && flush_count != 16'hFFFF)
            flush_count <= flush_count + 16'd1;
      end
   end

   always_comb begin
      state_nxt    = state;
      line_cnt_nxt = line_cnt;
      pending_nxt  = pending;
      unique case (state)
         IDLE: begin
            if (req)
               state_nxt = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            // requests arriving here are covered by the flush about to start
            if (i_cache_idle) begin
               state_nxt    = FLUSH;
               line_cnt_nxt = '0;
            end
         end
         FLUSH: begin
            line_cnt_nxt = line_cnt + 1'b1;
            if (req)
               pending_nxt = 1'b1;
            if (line_cnt == LAST_LINE)
               state_nxt = DONE;
         end
         DONE: begin
            // any number of late requests collapse into a single re-flush
            pending_nxt = 1'b0;
            state_nxt   = (pending || req) ? WAIT_IDLE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_busy        = (state != IDLE);
   assign o_stall       = (state != IDLE);
   assign o_tag_wenable = (state == FLUSH);
   assign o_tag_addr    = (state == FLUSH) ? line_cnt : '0;
   assign o_tag_wdata   = '0;
   assign o_flush_done  = (state == DONE);
   assign o_flush_count = flush_count;

endmodule

// File: tb/tb_a25_cache_flush_ctrl.sv
// Self-checking bench for a25_cache_flush_ctrl: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_a25_cache_flush_ctrl;

   localparam int L = 8;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_flush_req = 1'b0;
   logic          i_disruptive_hit = 1'b0;
   logic          i_cache_idle = 1'b1;
   logic          o_stall, o_busy, o_tag_wenable, o_flush_done;
   logic [2:0]    o_tag_addr;
   logic [20:0]   o_tag_wdata;
   logic [15:0]   o_flush_count;

   a25_cache_flush_ctrl #(.CACHE_LINES(L), .CACHE_LINE_W(3), .TAG_W(21)) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_flush_req      (i_flush_req),
      .i_disruptive_hit (i_disruptive_hit),
      .i_cache_idle     (i_cache_idle),
      .o_stall          (o_stall),
      .o_busy           (o_busy),
      .o_tag_wenable    (o_tag_wenable),
      .o_tag_addr       (o_tag_addr),
      .o_tag_wdata      (o_tag_wdata),
      .o_flush_done     (o_flush_done),
      .o_flush_count    (o_flush_count)
   );

   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a flush is "in progress" while active; before the cache
   // drains it is waiting; then pos walks the lines 0..L-1 and pos==L is the
   // completion cycle. owed records a request that arrived after the sweep began.
   bit m_act, m_wait, m_owed;
   int m_pos, m_count;
   int wr_seen, done_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_clock(input logic fr, input logic dh, input logic idle, input logic rst);
      bit req;
      req = fr | dh;
      if (rst) begin
         m_act = 0; m_wait = 0; m_owed = 0; m_pos = 0; m_count = 0;
      end else if (!m_act) begin
         if (req) begin m_act = 1; m_wait = 1; end
      end else if (m_wait) begin
         if (idle) begin m_wait = 0; m_pos = 0; end
      end else if (m_pos < L) begin
         m_pos++;
         if (req) m_owed = 1;
      end else begin
         m_count = (m_count < 16'hFFFF) ? m_count + 1 : m_count;
         if (m_owed || req) begin m_wait = 1; m_owed = 0; end
         else m_act = 0;
      end
   endtask

   task automatic check_outputs();
      bit wen;
      wen = m_act && !m_wait && m_pos < L;
      chk("stall", o_stall, m_act);
      chk("busy", o_busy, m_act);
      chk("tag_wenable", o_tag_wenable, wen);
      chk("tag_addr", o_tag_addr, wen ? m_pos : 0);
      chk("tag_wdata", o_tag_wdata, 0);
      chk("flush_done", o_flush_done, m_act && !m_wait && m_pos == L);
      chk("flush_count", o_flush_count, m_count);
      if (o_tag_wenable) wr_seen++;
      if (o_flush_done) done_seen++;
   endtask

   task automatic step(input logic fr, input logic dh, input logic idle, input logic rst);
      i_flush_req = fr; i_disruptive_hit = dh; i_cache_idle = idle; i_reset = rst;
      @(posedge i_clk);
      model_clock(fr, dh, idle, rst);
      #1;
      check_outputs();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, 0);
   endtask

   // advance until the model shows line p being written; bounded
   task automatic advance_to_line(input int p);
      int i;
      i = 0;
      while (!(m_act && !m_wait && m_pos == p) && i < 40) begin
         step(0, 0, 1, 0);
         i++;
      end
      chk("reach_line", (o_tag_wenable && o_tag_addr == p[2:0]) ? 1 : 0, 1);
   endtask

   task automatic advance_to_done();
      int i;
      i = 0;
      while (!(m_act && !m_wait && m_pos == L) && i < 40) begin
         step(0, 0, 1, 0);
         i++;
      end
      chk("reach_done", o_flush_done, 1);
   endtask

   initial begin
      int c0;
      m_act = 0; m_wait = 0; m_owed = 0; m_pos = 0; m_count = 0;
      wr_seen = 0; done_seen = 0;

      // 1: reset, request at cycle 5, full sweep with cache idle
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      idle_cycles(5);
      wr_seen = 0; done_seen = 0;
      step(1, 0, 1, 0);
      chk("t1_stall_rise", o_stall, 1);
      idle_cycles(12);
      chk("t1_writes", wr_seen, L);
      chk("t1_dones", done_seen, 1);
      chk("t1_count", o_flush_count, 1);

      // 2: cache busy for 4 cycles after the request
      wr_seen = 0;
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      chk("t2_no_write_while_busy", wr_seen, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("t2_first_write", o_tag_wenable, 1);
      idle_cycles(12);

      // 3: request during line 3 write, disruptive hit during done -> one re-flush
      c0 = o_flush_count;
      wr_seen = 0; done_seen = 0;
      step(1, 0, 1, 0);
      advance_to_line(3);
      step(1, 0, 1, 0);
      advance_to_done();
      step(0, 1, 1, 0);
      chk("t3_stall_held", o_stall, 1);
      idle_cycles(25);
      chk("t3_writes", wr_seen, 2 * L);
      chk("t3_dones", done_seen, 2);
      chk("t3_count", o_flush_count, c0 + 2);

      // 4: reset while line 5 is written
      done_seen = 0;
      step(1, 0, 1, 0);
      advance_to_line(5);
      step(0, 0, 1, 1);
      chk("t4_idle_after_reset", o_busy, 0);
      idle_cycles(12);
      chk("t4_no_done", done_seen, 0);

      // 5: saturation from FFFE
      force dut.flush_count = 16'hFFFE;
      m_count = 16'hFFFE;
      step(0, 0, 1, 0);
      release dut.flush_count;
      step(0, 0, 1, 0);
      step(1, 0, 1, 0);
      idle_cycles(12);
      chk("t5_count_ffff", o_flush_count, 16'hFFFF);
      step(1, 0, 1, 0);
      idle_cycles(12);
      chk("t5_count_sat", o_flush_count, 16'hFFFF);

      // 6: both request sources in the same idle cycle
      wr_seen = 0; done_seen = 0;
      step(1, 1, 1, 0);
      idle_cycles(14);
      chk("t6_writes", wr_seen, L);
      chk("t6_dones", done_seen, 1);

      // random traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom % 20) == 0, ($urandom % 30) == 0,
              ($urandom % 4) != 0, ($urandom % 300) == 0);
      idle_cycles(30);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
